// File: rtl/xrv_div_pkg.sv
// Shared types and helpers for the xrv iterative divider.
//   div_op_e : RV M-extension divide/remainder opcodes as presented on op_i
//   state_e  : divider control states
//   is_signed/is_rem : opcode decode helpers
package xrv_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    function automatic logic is_signed(input div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem(input div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/xrv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference when it does not
// borrow.
//   rem_i     : partial remainder in (XLEN+1 bits)
//   divisor_i : divisor magnitude
//   bit_i     : next dividend bit, MSB first
//   rem_o     : partial remainder out
//   q_bit_o   : quotient bit produced by this step
module xrv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            bit_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;

    assign shifted = {rem_i[XLEN-1:0], bit_i};
    assign trial   = {1'b0, shifted} - {2'b00, divisor_i};

    // A set top remainder bit means the shifted value exceeds any XLEN-bit
    // divisor, so the subtraction always succeeds in that case.
    assign q_bit_o = rem_i[XLEN] | ~trial[XLEN+1];
    assign rem_o   = q_bit_o ? trial[XLEN:0] : shifted;

endmodule

// File: rtl/xrv_div_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with valid/ready on both
// sides, opaque tag pass-through and flush.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   in_valid_i/in_ready_o, dividend_i, divisor_i, op_i, in_tag_i : request
//   flush_i             : abort any in-flight op, result discarded
//   out_valid_o/out_ready_i, result_o, out_tag_o : response
//
// state | meaning
// IDLE  | ready for a new op
// CALC  | retiring BITS_PER_CYCLE quotient bits per cycle
// FIX   | sign correction, load result
// DONE  | result presented until accepted
module xrv_div_seq
    import xrv_div_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [XLEN-1:0]  dividend_i,
    input  logic [XLEN-1:0]  divisor_i,
    input  logic [1:0]       op_i,
    input  logic [TAG_W-1:0] in_tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] out_tag_o
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 2) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS - 1);
    localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    div_op_e          op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    // quo_q starts as |dividend| and shifts left each step: its MSBs feed the
    // step chain while quotient bits enter at the bottom.
    logic [XLEN:0]             rem_chain [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] q_bits;

    assign rem_chain[0] = rem_q;

    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        xrv_div_step #(.XLEN(XLEN)) u_step (
            .rem_i     (rem_chain[k]),
            .divisor_i (dvs_q),
            .bit_i     (quo_q[XLEN-1-k]),
            .rem_o     (rem_chain[k+1]),
            .q_bit_o   (q_bits[BITS_PER_CYCLE-1-k])
        );
    end

    div_op_e         op_in;
    logic            accept;
    logic            a_neg, b_neg;
    logic            div_zero, sgn_ovf;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] rem_lo;

    always_comb begin
        op_in    = div_op_e'(op_i);
        accept   = in_valid_i & (state_q == IDLE) & ~flush_i;
        a_neg    = is_signed(op_in) & dividend_i[XLEN-1];
        b_neg    = is_signed(op_in) & divisor_i[XLEN-1];
        div_zero = (divisor_i == '0);
        sgn_ovf  = is_signed(op_in) & (dividend_i == MIN_VAL) & (divisor_i == '1);
        if (div_zero)
            special_res = is_rem(op_in) ? dividend_i : '1;
        else
            special_res = is_rem(op_in) ? '0 : MIN_VAL;
        rem_lo = rem_q[XLEN-1:0];

        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        op_d      = op_q;
        tag_d     = tag_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        out_tag_d = out_tag_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = op_in;
                    tag_d     = in_tag_i;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    // Negating MIN yields MIN, which is the correct unsigned magnitude.
                    quo_d     = a_neg ? -dividend_i : dividend_i;
                    dvs_d     = b_neg ? -divisor_i : divisor_i;
                    rem_d     = '0;
                    cnt_d     = CNT_LOAD;
                    if (div_zero || sgn_ovf) begin
                        result_d  = special_res;
                        out_tag_d = in_tag_i;
                        state_d   = DONE;
                    end else begin
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_chain[BITS_PER_CYCLE];
                quo_d = {quo_q[XLEN-1-BITS_PER_CYCLE:0], q_bits};
                if (cnt_q == '0)
                    state_d = FIX;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            FIX: begin
                if (is_rem(op_q))
                    result_d = neg_rem_q ? -rem_lo : rem_lo;
                else
                    result_d = neg_quo_q ? -quo_q : quo_q;
                out_tag_d = tag_q;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush_i)
            state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            op_q      <= DIV;
            tag_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign result_o    = result_q;
    assign out_tag_o   = out_tag_q;

endmodule

// File: tb/tb_xrv_div_seq.sv
// Self-checking bench for xrv_div_seq. Instance 0 (XLEN=32, one bit per
// cycle) takes the directed scenarios; all instances take random ops checked
// against a plain-arithmetic reference.
module tb_xrv_div_seq;

    localparam int NC      = 5;
    localparam int LAT_MAX = 200;

    function automatic int cfg_xlen(input int c);
        return (c < 3) ? 32 : 64;
    endfunction

    function automatic int cfg_bpc(input int c);
        case (c)
            0: return 1;
            1: return 2;
            2: return 4;
            3: return 1;
            default: return 4;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] in_valid = '0;
    logic [NC-1:0] in_ready;
    logic [NC-1:0] out_valid;
    logic [NC-1:0] out_ready = '0;
    logic          flush = 1'b0;
    logic [63:0]   dividend = '0;
    logic [63:0]   divisor = '0;
    logic [1:0]    op_s = 2'b00;
    logic [4:0]    in_tag = '0;
    logic [63:0]   result  [NC];
    logic [4:0]    out_tag [NC];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        localparam int XL = cfg_xlen(g);
        localparam int BP = cfg_bpc(g);
        logic [XL-1:0] res;
        xrv_div_seq #(.XLEN(XL), .BITS_PER_CYCLE(BP), .TAG_W(5)) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .in_valid_i  (in_valid[g]),
            .in_ready_o  (in_ready[g]),
            .dividend_i  (dividend[XL-1:0]),
            .divisor_i   (divisor[XL-1:0]),
            .op_i        (op_s),
            .in_tag_i    (in_tag),
            .flush_i     (flush),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready[g]),
            .result_o    (res),
            .out_tag_o   (out_tag[g])
        );
        assign result[g] = 64'(res);
    end

    function automatic logic [63:0] xmask(input int xl);
        return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] xmin(input int xl);
        return (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    endfunction

    // RV semantics from plain integer arithmetic (SV / and % truncate toward zero).
    function automatic logic [63:0] ref_div(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input int xl);
        logic [63:0] m, ua, ub, r;
        logic [31:0] a32, b32;
        longint      sa, sb;
        bit          sgn, rem;
        m   = xmask(xl);
        ua  = a & m;
        ub  = b & m;
        a32 = ua[31:0];
        b32 = ub[31:0];
        sgn = (op == 2'b00) || (op == 2'b10);
        rem = (op == 2'b10) || (op == 2'b11);
        if (xl == 32) begin
            sa = longint'($signed(a32));
            sb = longint'($signed(b32));
        end else begin
            sa = $signed(ua);
            sb = $signed(ub);
        end
        if (ub == 64'd0)
            r = rem ? ua : m;
        else if (sgn && ua == xmin(xl) && ub == m)
            r = rem ? 64'd0 : xmin(xl);
        else if (sgn)
            r = rem ? 64'(sa % sb) : 64'(sa / sb);
        else
            r = rem ? (ua % ub) : (ua / ub);
        return r & m;
    endfunction

    // Drive one op on instance c; lat counts clock edges from the accepting
    // edge (inclusive) to the edge after which out_valid is first seen.
    task automatic run_op(input int c, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag, input bit ack,
                          output logic [63:0] res, output logic [4:0] otag, output int lat);
        @(negedge clk);
        op_s = op; dividend = a; divisor = b; in_tag = tag;
        in_valid[c] = 1'b1;
        @(posedge clk); #1;
        in_valid[c] = 1'b0;
        lat = 1;
        while (out_valid[c] !== 1'b1 && lat < LAT_MAX) begin
            @(posedge clk); #1;
            lat++;
        end
        res  = result[c];
        otag = out_tag[c];
        if (ack) begin
            out_ready[c] = 1'b1;
            @(posedge clk); #1;
            out_ready[c] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            tests++;
            if (in_ready[c] !== 1'b1 || out_valid[c] !== 1'b0 || result[c] !== 64'd0 || out_tag[c] !== 5'd0) begin
                fails++;
                $display("FAIL reset[%0d]: in_ready=%b out_valid=%b result=%h tag=%h, required 1 0 0 0",
                         c, in_ready[c], out_valid[c], result[c], out_tag[c]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  tops [10];
        logic [31:0] ta   [10];
        logic [31:0] tb   [10];
        logic [31:0] texp [10];
        int          tlat [10];
        logic [63:0] res;
        logic [4:0]  otag;
        int          lat;
        tops = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10};
        ta   = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        tb   = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        texp = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1,
                 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        tlat = '{34, 34, 34, 34, 34, 34, 1, 1, 1, 1};
        for (int i = 0; i < 10; i++) begin
            run_op(0, tops[i], {32'd0, ta[i]}, {32'd0, tb[i]}, 5'(i + 3), 1'b1, res, otag, lat);
            tests++;
            if (res !== {32'd0, texp[i]}) begin
                fails++;
                $display("FAIL directed[%0d] result: got %h, required %h", i, res, texp[i]);
            end
            tests++;
            if (lat !== tlat[i]) begin
                fails++;
                $display("FAIL directed[%0d] latency: got %0d, required %0d", i, lat, tlat[i]);
            end
            tests++;
            if (otag !== 5'(i + 3)) begin
                fails++;
                $display("FAIL directed[%0d] tag: got %0d, required %0d", i, otag, i + 3);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] res, exp;
        logic [4:0]  otag;
        int          lat;
        exp = ref_div(2'b00, 64'h0000_0000_8765_4321, 64'd1234, 32);
        run_op(0, 2'b00, 64'h0000_0000_8765_4321, 64'd1234, 5'd21, 1'b0, res, otag, lat);
        @(negedge clk);
        op_s = 2'b01; dividend = 64'd50; divisor = 64'd5; in_tag = 5'd9;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            tests++;
            if (out_valid[0] !== 1'b1 || result[0] !== exp || out_tag[0] !== 5'd21 || in_ready[0] !== 1'b0) begin
                fails++;
                $display("FAIL backpressure[%0d]: valid=%b result=%h tag=%0d in_ready=%b, required 1 %h 21 0",
                         i, out_valid[0], result[0], out_tag[0], in_ready[0], exp);
            end
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        run_op(0, 2'b01, 64'd50, 64'd5, 5'd9, 1'b1, res, otag, lat);
        tests++;
        if (res !== 64'd10 || otag !== 5'd9 || lat !== 34) begin
            fails++;
            $display("FAIL backpressure_next: result=%h tag=%0d lat=%0d, required 10 9 34", res, otag, lat);
        end
    endtask

    task automatic test_flush();
        logic [63:0] res;
        logic [4:0]  otag;
        int          lat;
        int          seen;
        @(negedge clk);
        op_s = 2'b01; dividend = 64'd1000; divisor = 64'd3; in_tag = 5'd4;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        op_s = 2'b00; dividend = 64'd77; divisor = 64'd7; in_tag = 5'd30;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid[0] = 1'b0;
        tests++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: in_ready=%b out_valid=%b, required 1 0", in_ready[0], out_valid[0]);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid[0] === 1'b1 || in_ready[0] !== 1'b1) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL flush_quiet: %0d cycles with out_valid or busy, required 0", seen);
        end
        run_op(0, 2'b01, 64'd9, 64'd3, 5'd11, 1'b1, res, otag, lat);
        tests++;
        if (res !== 64'd3 || otag !== 5'd11 || lat !== 34) begin
            fails++;
            $display("FAIL flush_next: result=%h tag=%0d lat=%0d, required 3 11 34", res, otag, lat);
        end
        // Flush in DONE wins over a simultaneous out_ready.
        run_op(0, 2'b11, 64'd23, 64'd5, 5'd2, 1'b0, res, otag, lat);
        @(negedge clk);
        flush = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        out_ready[0] = 1'b0;
        tests++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || res !== 64'd3) begin
            fails++;
            $display("FAIL flush_done: out_valid=%b in_ready=%b result=%h, required 0 1 3",
                     out_valid[0], in_ready[0], res);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op_s = 2'b00; dividend = 64'd12345; divisor = 64'd17; in_tag = 5'd19;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || result[0] !== 64'd0 || out_tag[0] !== 5'd0) begin
            fails++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b result=%h tag=%0d, required 1 0 0 0",
                     in_ready[0], out_valid[0], result[0], out_tag[0]);
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, m, exp, res;
        logic [1:0]  op;
        logic [4:0]  tag, otag;
        int          lat, xl, sel, elat;
        bit          special;
        for (int c = 0; c < NC; c++) begin
            xl = cfg_xlen(c);
            m  = xmask(xl);
            for (int n = 0; n < 25; n++) begin
                op  = 2'($urandom_range(0, 3));
                tag = 5'($urandom);
                a   = {$urandom, $urandom};
                b   = {$urandom, $urandom} >> $urandom_range(0, xl - 1);
                sel = $urandom_range(0, 9);
                if (sel == 0) b = 64'd0;
                else if (sel == 1) begin a = xmin(xl); b = m; end
                else if (sel == 2) b = 64'($urandom_range(1, 15));
                else if (sel == 3) b = ~64'($urandom_range(0, 6));
                a = a & m;
                b = b & m;
                exp = ref_div(op, a, b, xl);
                special = (b == 64'd0) || (!op[0] && a == xmin(xl) && b == m);
                elat = special ? 1 : (xl / cfg_bpc(c) + 2);
                run_op(c, op, a, b, tag, 1'b1, res, otag, lat);
                tests++;
                if (res !== exp || otag !== tag || lat !== elat) begin
                    fails++;
                    $display("FAIL random[c%0d,%0d] op=%0d a=%h b=%h: result=%h tag=%0d lat=%0d, required %h %0d %0d",
                             c, n, op, a, b, res, otag, lat, exp, tag, elat);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
